// File: rtl/register_pkg.sv
// ----------------------------------------------------------------------------
// register_pkg
//
// Shared definitions for the register family of blocks.
//
// Contents:
//   DEFAULT_WIDTH  - default data width for register blocks
//   DEFAULT_STAGES - default number of pipeline stages
//   countWidth()   - bits needed to hold an occupancy value of 0..stages
// ----------------------------------------------------------------------------
package register_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_STAGES = 2;

    // An occupancy counter must represent every value from empty (0) up to
    // completely full (stages), so it needs clog2(stages+1) bits.
    function automatic int countWidth(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_register_if.sv
// ----------------------------------------------------------------------------
// pipe_register_if
//
// Handshake bundle for the elastic pipeline register.
//
// Signals:
//   in_valid  - producer has a word on in_data
//   in_data   - input word (WIDTH bits)
//   in_ready  - pipeline accepts in_data this cycle
//   out_valid - out_data holds a valid word
//   out_data  - oldest held word (WIDTH bits)
//   out_ready - consumer takes out_data this cycle
//   count     - number of occupied stages
//
// Modports:
//   master - the environment side (drives producer data and consumer ready)
//   slave  - the pipeline side
// ----------------------------------------------------------------------------
interface pipe_register_if
    import register_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) ();

    localparam int CW = countWidth(STAGES);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
//
// One stage of the elastic pipeline: a valid bit plus a data word.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset (clears valid and data)
//   flush    - synchronous clear of the valid bit
//   load_i   - stage may take the upstream word this cycle
//   upVld_i  - upstream valid
//   upDat_i  - upstream data
//   vld_o    - stage holds a valid word
//   dat_o    - word held by the stage
// ----------------------------------------------------------------------------
module pipe_stage
    import register_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load_i,
    input  logic             upVld_i,
    input  logic [WIDTH-1:0] upDat_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dat_o
);

    logic             vld_q;
    logic             vld_d;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] dat_d;

    // When the stage is allowed to load it copies the upstream valid bit,
    // which is how a bubble moves forward. The data word only changes when
    // a real word arrives, so an emptied stage keeps showing its last word.
    // Flush drops the valid bit but deliberately leaves the data alone.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (load_i) begin
            vld_d = upVld_i;
            if (upVld_i) begin
                dat_d = upDat_i;
            end
        end
        if (flush) begin
            vld_d = 1'b0;
        end
    end

    // Stage storage; reset clears both the valid bit and the data word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipe_register.sv
// ----------------------------------------------------------------------------
// pipe_register
//
// Parametrised elastic pipeline register with valid/ready handshake,
// per-stage back-pressure with bubble collapse, synchronous flush and an
// occupancy counter.
//
// Parameters:
//   WIDTH  - data width in bits (>= 1)
//   STAGES - number of register stages (>= 1)
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   flush - synchronous clear of every stage; input is refused that cycle
//   bus   - pipe_register_if slave: in_valid/in_data/in_ready on the
//           producer side, out_valid/out_data/out_ready on the consumer
//           side, and count (number of occupied stages)
// ----------------------------------------------------------------------------
module pipe_register
    import register_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    pipe_register_if.slave bus
);

    localparam int CW = countWidth(STAGES);

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0][WIDTH-1:0] dat;
    logic [STAGES:0]              rdy;
    logic                         accept;
    logic                         emit;
    logic [CW-1:0]                count_q;
    logic [CW-1:0]                count_d;

    // Ready ripples backwards from the consumer: a stage can take a word if
    // it is empty or if the stage ahead of it is itself ready. Because this
    // is combinational, an empty stage anywhere lets everything behind it
    // advance, which is what collapses bubbles under back-pressure.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld[k] || rdy[k+1];
        end
    end

    // Stage 0 is fed from the producer (gated off during flush so the
    // incoming word is dropped); every later stage is fed from its
    // predecessor.
    for (genvar k = 0; k < STAGES; k++) begin : gStage
        logic             upVld;
        logic [WIDTH-1:0] upDat;

        if (k == 0) begin : gHead
            assign upVld = bus.in_valid && !flush;
            assign upDat = bus.in_data;
        end else begin : gBody
            assign upVld = vld[k-1];
            assign upDat = dat[k-1];
        end

        pipe_stage #(
            .WIDTH (WIDTH)
        ) uStage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .load_i  (rdy[k]),
            .upVld_i (upVld),
            .upDat_i (upDat),
            .vld_o   (vld[k]),
            .dat_o   (dat[k])
        );
    end

    assign bus.in_ready  = rdy[0] && !flush;
    assign bus.out_valid = vld[STAGES-1];
    assign bus.out_data  = dat[STAGES-1];

    assign accept = bus.in_valid && bus.in_ready;
    assign emit   = bus.out_valid && bus.out_ready;

    // Occupancy tracks accepts minus emits so it always matches the number
    // of valid stages. An emit during a flush cycle is a genuine transfer to
    // the consumer, but the flush empties everything anyway, so the counter
    // simply goes to zero.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (accept && !emit) begin
            count_d = count_q + CW'(1);
        end else if (emit && !accept) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_pipe_register.sv
// ----------------------------------------------------------------------------
// tb_pipe_register
//
// Self-checking bench for pipe_register. A directed instance (WIDTH=4,
// STAGES=2) runs a vector table plus hand-written stream / reset sequences.
// Three further instances (4/2, 8/1, 8/4) run randomized traffic against a
// reference model that keeps the in-flight words as a queue with a position
// per word.
// ----------------------------------------------------------------------------
module tb_pipe_register;

    logic clk;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Directed-test instance.
    logic rstMain;
    logic flushMain;

    pipe_register_if #(.WIDTH(4), .STAGES(2)) busMain ();

    pipe_register #(
        .WIDTH  (4),
        .STAGES (2)
    ) uDut (
        .clk   (clk),
        .rst   (rstMain),
        .flush (flushMain),
        .bus   (busMain)
    );

    // Every comparison goes through here so the counters stay consistent.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and let them settle.
    task automatic applyStimulus(input bit inV, input logic [3:0] d, input bit outR, input bit fl);
        @(negedge clk);
        busMain.in_valid  = inV;
        busMain.in_data   = d;
        busMain.out_ready = outR;
        flushMain         = fl;
        #1;
    endtask

    task automatic checkAll(input string tag, input bit eInReady, input bit eOutValid,
                            input logic [3:0] eOutData, input int eCount);
        checkOutput({tag, " in_ready"},  32'(busMain.in_ready),  32'(eInReady));
        checkOutput({tag, " out_valid"}, 32'(busMain.out_valid), 32'(eOutValid));
        checkOutput({tag, " out_data"},  32'(busMain.out_data),  32'(eOutData));
        checkOutput({tag, " count"},     32'(busMain.count),     32'(eCount));
    endtask

    typedef struct {
        bit         inV;
        logic [3:0] d;
        bit         outR;
        bit         fl;
        bit         eInReady;
        bit         eOutValid;
        logic [3:0] eOutData;
        int         eCount;
    } vec_t;

    vec_t tbl[22];

    // ------------------------------------------------------------------
    // Randomized instances with a queue-of-positions reference model.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < 3; g++) begin : gRand
        localparam int W = (g == 0) ? 4 : 8;
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 4;

        logic rstR;
        logic flushR;

        pipe_register_if #(.WIDTH(W), .STAGES(S)) busR ();

        pipe_register #(
            .WIDTH  (W),
            .STAGES (S)
        ) uDutR (
            .clk   (clk),
            .rst   (rstR),
            .flush (flushR),
            .bus   (busR)
        );

        logic [W-1:0] qData[$];
        int           qPos[$];
        bit           stay[$];
        logic [W-1:0] nData[$];
        int           nPos[$];
        logic [W-1:0] lastOut;
        logic [W-1:0] rndData;
        bit           inV;
        bit           outR;
        bit           fl;
        bit           inReadyM;
        bit           outVM;
        int           n;
        bit           done;

        initial begin
            done              = 1'b0;
            rstR              = 1'b0;
            flushR            = 1'b0;
            busR.in_valid     = 1'b0;
            busR.in_data      = '0;
            busR.out_ready    = 1'b0;
            lastOut           = '0;
            @(negedge clk);
            #1;
            checkOutput($sformatf("cfg%0d reset out_valid", g), 32'(busR.out_valid), 32'd0);
            checkOutput($sformatf("cfg%0d reset count", g),     32'(busR.count),     32'd0);
            checkOutput($sformatf("cfg%0d reset out_data", g),  32'(busR.out_data),  32'd0);
            rstR = 1'b1;

            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                inV     = $urandom_range(0, 3) != 0;
                outR    = (cyc % 64 < 32) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
                fl      = $urandom_range(0, 29) == 0;
                rndData = W'($urandom);
                busR.in_valid  = inV;
                busR.in_data   = rndData;
                busR.out_ready = outR;
                flushR         = fl;
                #1;

                // A word stays put when it sits at the output without a
                // taker, or when the word directly ahead of it stays put.
                n = qPos.size();
                stay.delete();
                for (int i = 0; i < n; i++) begin
                    if (qPos[i] == S - 1) begin
                        stay.push_back(!outR);
                    end else begin
                        stay.push_back((i > 0) && stay[i-1] && (qPos[i-1] == qPos[i] + 1));
                    end
                end
                inReadyM = !fl && !((n > 0) && (qPos[n-1] == 0) && stay[n-1]);
                outVM    = (n > 0) && (qPos[0] == S - 1);

                checkOutput($sformatf("cfg%0d cyc%0d in_ready", g, cyc),  32'(busR.in_ready),  32'(inReadyM));
                checkOutput($sformatf("cfg%0d cyc%0d out_valid", g, cyc), 32'(busR.out_valid), 32'(outVM));
                checkOutput($sformatf("cfg%0d cyc%0d out_data", g, cyc),  32'(busR.out_data),  32'(lastOut));
                checkOutput($sformatf("cfg%0d cyc%0d count", g, cyc),     32'(busR.count),     32'(n));

                // Advance the model across the coming rising edge.
                nData.delete();
                nPos.delete();
                for (int i = 0; i < n; i++) begin
                    if (!(i == 0 && outVM && outR)) begin
                        if (stay[i]) begin
                            nPos.push_back(qPos[i]);
                        end else begin
                            nPos.push_back(qPos[i] + 1);
                            if (qPos[i] + 1 == S - 1) begin
                                lastOut = qData[i];
                            end
                        end
                        nData.push_back(qData[i]);
                    end
                end
                if (inV && inReadyM) begin
                    nData.push_back(rndData);
                    nPos.push_back(0);
                    if (S == 1) begin
                        lastOut = rndData;
                    end
                end
                if (fl) begin
                    nData.delete();
                    nPos.delete();
                end
                qData = nData;
                qPos  = nPos;
            end
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Directed sequence on the main instance.
    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;

        // Fill, stall, drain, bubble collapse, full accept+emit, flush.
        tbl[0]  = '{1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 0};
        tbl[1]  = '{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1};
        tbl[2]  = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 2};
        tbl[3]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'hA, 2};
        tbl[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 2};
        tbl[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hB, 1};
        tbl[6]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 0};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1};
        tbl[8]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1};
        tbl[9]  = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 2};
        tbl[10] = '{1'b1, 4'h7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 2};
        tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5, 2};
        tbl[12] = '{1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 2};
        tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 0};
        tbl[14] = '{1'b1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 0};
        tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 1};
        tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'hE, 1};
        tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE, 0};
        tbl[18] = '{1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE, 0};
        tbl[19] = '{1'b1, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0, 4'hE, 1};
        tbl[20] = '{1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 2};
        tbl[21] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h2, 0};

        rstMain           = 1'b0;
        flushMain         = 1'b0;
        busMain.in_valid  = 1'b0;
        busMain.in_data   = '0;
        busMain.out_ready = 1'b0;
        #3;
        checkOutput("reset out_valid", 32'(busMain.out_valid), 32'd0);
        checkOutput("reset out_data",  32'(busMain.out_data),  32'd0);
        checkOutput("reset count",     32'(busMain.count),     32'd0);
        @(negedge clk);
        rstMain = 1'b1;
        #1;
        checkOutput("post-reset in_ready", 32'(busMain.in_ready), 32'd1);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(tbl[i].inV, tbl[i].d, tbl[i].outR, tbl[i].fl);
            checkAll($sformatf("vec%0d", i), tbl[i].eInReady, tbl[i].eOutValid,
                     tbl[i].eOutData, tbl[i].eCount);
        end

        // Full-rate stream of 0..15: word c appears two edges after accept.
        for (int c = 0; c < 19; c++) begin
            int accepted;
            int emitted;
            applyStimulus(c < 16, 4'(c), 1'b1, 1'b0);
            accepted = (c < 16) ? c : 16;
            emitted  = (c < 2) ? 0 : ((c - 2 < 16) ? c - 2 : 16);
            checkAll($sformatf("stream%0d", c), 1'b1, (c >= 2) && (c < 18),
                     (c < 2) ? 4'h2 : ((c < 18) ? 4'(c - 2) : 4'hF),
                     accepted - emitted);
        end

        // Fill, then pull reset between edges: state must vanish at once.
        applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'hD, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
        checkAll("full before reset", 1'b0, 1'b1, 4'hC, 2);
        #2;
        rstMain = 1'b0;
        #1;
        checkOutput("async reset out_valid", 32'(busMain.out_valid), 32'd0);
        checkOutput("async reset out_data",  32'(busMain.out_data),  32'd0);
        checkOutput("async reset count",     32'(busMain.count),     32'd0);
        @(negedge clk);
        rstMain = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
            checkAll($sformatf("after reset%0d", c), 1'b1, 1'b0, 4'h0, 0);
        end

        // Wait, bounded, for the randomized instances.
        for (int t = 0; t < 3000; t++) begin
            if (gRand[0].done && gRand[1].done && gRand[2].done) begin
                break;
            end
            @(posedge clk);
        end
        checkOutput("random runs finished", 32'(gRand[0].done && gRand[1].done && gRand[2].done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
